// File: rtl/pcm_tdm_decoder_if.sv
// pcm_tdm_decoder_if
//   Groups the line-side inputs and decoded outputs of pcm_tdm_decoder.
//   master: the line/stimulus side. It drives bit_en, sdi, fsync and slot_sel,
//           and observes the decoded outputs.
//   slave : the decoder side. It consumes the line inputs and drives
//           pcm_code, lin_out, dac_out, valid and locked.
interface pcm_tdm_decoder_if #(
  parameter int NSLOT = 32
);
  logic                     bit_en;
  logic                     sdi;
  logic                     fsync;
  logic [$clog2(NSLOT)-1:0] slot_sel;
  logic [7:0]               pcm_code;
  logic [12:0]              lin_out;
  logic [7:0]               dac_out;
  logic                     valid;
  logic                     locked;

  modport master (
    output bit_en, sdi, fsync, slot_sel,
    input  pcm_code, lin_out, dac_out, valid, locked
  );

  modport slave (
    input  bit_en, sdi, fsync, slot_sel,
    output pcm_code, lin_out, dac_out, valid, locked
  );
endinterface

// File: rtl/pcm_tdm_decoder.sv
// pcm_tdm_decoder
//   Recovers frame alignment from a serial TDM PCM stream of 8-bit A-law words
//   sent MSB first. It extracts one selected timeslot per frame, expands the
//   A-law code to 13-bit signed linear, and also gives the result as 8-bit
//   offset binary for a DAC.
// Ports
//   sys_clk  : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : pcm_tdm_decoder_if.slave
//              inputs : bit_en strobe, sdi, fsync, slot_sel
//              outputs: pcm_code (received line code), lin_out, dac_out,
//                       valid (one-cycle pulse), locked
module pcm_tdm_decoder #(
  parameter int NSLOT       = 32,
  parameter int MISS_MAX    = 3,
  parameter int INVERT_EVEN = 1
) (
  input logic              sys_clk,
  input logic              reset,
  pcm_tdm_decoder_if.slave bus
);

  localparam int SW = $clog2(NSLOT);
  localparam int BW = SW + 3;
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(NSLOT * 8 - 1);
  localparam logic [MW-1:0] MISS_LAST  = MW'(MISS_MAX - 1);
  localparam logic [7:0]    INV_MASK   = (INVERT_EVEN != 0) ? 8'h55 : 8'h00;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bidx_q, bidx_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      pcm_q, pcm_d;
  logic [12:0]     lin_q, lin_d;
  logic [7:0]      dac_q, dac_d;
  logic            valid_q, valid_d;

  logic [7:0]      word;
  logic [7:0]      code;
  logic [11:0]     mag;
  logic [12:0]     linNew;
  logic [7:0]      dacNew;
  logic            process;
  logic [BW-1:0]   curIdx;
  logic [SW-1:0]   curSlot;

  // A-law expansion of the word that would complete with the current sdi bit.
  // The segment value adds the implicit leading one above the mantissa, except
  // in segment 0. The code's sign bit set means a positive sample.
  always_comb begin
    word   = {shift_q[6:0], bus.sdi};
    code   = word ^ INV_MASK;
    mag    = '0;
    if (code[6:4] == 3'd0) begin
      mag = {7'd0, code[3:0], 1'b1};
    end else begin
      mag = 12'({1'b1, code[3:0], 1'b1}) << (code[6:4] - 3'd1);
    end
    linNew = code[7] ? {1'b0, mag} : (13'd0 - {1'b0, mag});
    dacNew = {~linNew[12], linNew[11:5]};
  end

  // Next-state logic.
  // Every bit of state moves only on bit_en cycles; the one exception is the
  // valid pulse, which drops back after a single cycle.
  // A boundary bit that takes the miss count to its limit is not processed.
  // It sends the block back to HUNT instead.
  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    miss_d  = miss_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    pcm_d   = pcm_q;
    lin_d   = lin_q;
    dac_d   = dac_q;
    valid_d = 1'b0;
    process = 1'b0;
    curIdx  = bidx_q;
    curSlot = slot_q;

    if (bus.bit_en) begin
      case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            state_d = LOCKED;
            process = 1'b1;
            curIdx  = '0;
            miss_d  = '0;
          end
        end
        LOCKED: begin
          process = 1'b1;
          if (bidx_q == '0) begin
            if (bus.fsync) begin
              miss_d = '0;
            end else if (miss_q == MISS_LAST) begin
              state_d = HUNT;
              process = 1'b0;
              miss_d  = '0;
              bidx_d  = '0;
              shift_d = '0;
            end else begin
              miss_d = miss_q + MW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (process) begin
      // The slot is re-latched at frame bit 0, and that same bit already uses the new value.
      if (curIdx == '0) begin
        slot_d  = bus.slot_sel;
        curSlot = bus.slot_sel;
      end
      bidx_d = (curIdx == FRAME_LAST) ? '0 : curIdx + BW'(1);
      if (curIdx[BW-1:3] == curSlot) begin
        shift_d = word;
        if (curIdx[2:0] == 3'd7) begin
          pcm_d   = word;
          lin_d   = linNew;
          dac_d   = dacNew;
          valid_d = 1'b1;
        end
      end
    end
  end

  // State and output registers.
  // The DAC output resets to midscale, not to zero.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      bidx_q  <= '0;
      miss_q  <= '0;
      slot_q  <= '0;
      shift_q <= '0;
      pcm_q   <= '0;
      lin_q   <= '0;
      dac_q   <= 8'h80;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      miss_q  <= miss_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      pcm_q   <= pcm_d;
      lin_q   <= lin_d;
      dac_q   <= dac_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pcm_code = pcm_q;
  assign bus.lin_out  = lin_q;
  assign bus.dac_out  = dac_q;
  assign bus.valid    = valid_q;
  assign bus.locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_pcm_tdm_decoder.sv
// tb_pcm_tdm_decoder
//   Directed bench for pcm_tdm_decoder. Each frame's expected result goes into
//   a queue when the frame is driven. A monitor pops an entry on every valid
//   pulse and compares it with the outputs.
module tb_pcm_tdm_decoder;

  localparam int NSLOT      = 32;
  localparam int FRAME_BITS = NSLOT * 8;

  logic sys_clk = 1'b0;
  logic reset;

  always #5 sys_clk = ~sys_clk;

  pcm_tdm_decoder_if #(.NSLOT(NSLOT)) bus ();

  pcm_tdm_decoder #(
    .NSLOT(NSLOT),
    .MISS_MAX(3),
    .INVERT_EVEN(1)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [7:0]  code;
    logic [12:0] lin;
    logic [7:0]  dac;
  } exp_t;

  exp_t       expQ[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] frameData [NSLOT];

  // One comparison: count it, and on a mismatch count an error and report it.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // G.711 A-law reference, written on the 16-bit scale and then divided down to 13 bits.
  function automatic logic [12:0] alawLin(input logic [7:0] c);
    int a, t, seg;
    a   = int'(c ^ 8'h55);
    t   = (a & 15) << 4;
    seg = (a >> 4) & 7;
    if (seg == 0) t = t + 8;
    else begin
      t = t + 264;
      t = t << (seg - 1);
    end
    t = t / 8;
    if ((a & 128) == 0) t = -t;
    return 13'(t);
  endfunction

  // Offset binary: shift the signed range up to 0..8191 and keep the top 8 bits.
  function automatic logic [7:0] dacOf(input logic [12:0] lin);
    int v;
    v = int'($signed(lin)) + 4096;
    return 8'(v >> 5);
  endfunction

  task automatic pushLiteral(input string tag, input logic [7:0] c, input logic [12:0] l, input logic [7:0] d);
    exp_t e;
    e.tag = tag; e.code = c; e.lin = l; e.dac = d;
    expQ.push_back(e);
  endtask

  task automatic pushModel(input string tag, input logic [7:0] c);
    pushLiteral(tag, c, alawLin(c), dacOf(alawLin(c)));
  endtask

  // Drive one line bit with a single-cycle bit_en strobe.
  task automatic applyStimulus(input logic b, input logic fs);
    bus.bit_en = 1'b1;
    bus.sdi    = b;
    bus.fsync  = fs;
    @(posedge sys_clk);
    #1;
    bus.bit_en = 1'b0;
    bus.sdi    = 1'b0;
    bus.fsync  = 1'b0;
  endtask

  task automatic fillFrame();
    for (int s = 0; s < NSLOT; s++) frameData[s] = 8'($urandom);
  endtask

  // Send the first nBits of frameData. gap>0 inserts an idle cycle after every gap bits.
  // spurAt raises fsync on that bit. chgAt changes slot_sel before that bit.
  task automatic sendFrame(input logic fs, input int nBits, input int gap,
                           input int spurAt, input int chgAt, input int newSel);
    for (int i = 0; i < nBits; i++) begin
      logic [7:0] w;
      w = frameData[i / 8];
      if (i == chgAt) bus.slot_sel = 5'(newSel);
      applyStimulus(w[7 - (i % 8)], (i == 0 && fs) || (i == spurAt));
      if (gap > 0 && (i % gap) == gap - 1) begin
        @(posedge sys_clk);
        #1;
      end
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge. A valid pulse with nothing queued is an error.
  always @(negedge sys_clk) begin
    if (reset === 1'b0 && bus.valid === 1'b1) begin
      checkOutput("valid_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        cur = expQ.pop_front();
        checkOutput({cur.tag, "_code"}, 32'(bus.pcm_code), 32'(cur.code));
        checkOutput({cur.tag, "_lin"},  32'(bus.lin_out),  32'(cur.lin));
        checkOutput({cur.tag, "_dac"},  32'(bus.dac_out),  32'(cur.dac));
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.bit_en   = 1'b0;
    bus.sdi      = 1'b0;
    bus.fsync    = 1'b0;
    bus.slot_sel = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("rst_code",   32'(bus.pcm_code), 32'h00);
    checkOutput("rst_lin",    32'(bus.lin_out),  32'h0);
    checkOutput("rst_dac",    32'(bus.dac_out),  32'h80);
    checkOutput("rst_valid",  32'(bus.valid),    32'd0);
    checkOutput("rst_locked", 32'(bus.locked),   32'd0);
    reset = 1'b0;
    @(posedge sys_clk);
    #1;

    // Line bits with no fsync leave the decoder hunting.
    for (int i = 0; i < 20; i++) applyStimulus(1'($urandom), 1'b0);
    checkOutput("hunt_locked", 32'(bus.locked), 32'd0);

    // Slot 0 carrying 0xD5 decodes to +1. Sent again with idle gaps between bit strobes.
    fillFrame(); frameData[0] = 8'hD5;
    pushLiteral("t1a", 8'hD5, 13'h0001, 8'h80);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);
    checkOutput("t1_locked", 32'(bus.locked), 32'd1);
    fillFrame(); frameData[0] = 8'hD5;
    pushLiteral("t1b", 8'hD5, 13'h0001, 8'h80);
    sendFrame(1'b1, FRAME_BITS, 3, -1, -1, 0);

    // Full-scale codes in slot 5.
    bus.slot_sel = 5'd5;
    fillFrame(); frameData[5] = 8'hAA;
    pushLiteral("t2pos", 8'hAA, 13'h0FC0, 8'hFE);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);
    fillFrame(); frameData[5] = 8'h2A;
    pushLiteral("t2neg", 8'h2A, 13'h1040, 8'h02);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);
    fillFrame(); frameData[5] = 8'h55;
    pushLiteral("t3m1", 8'h55, 13'h1FFF, 8'h7F);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);

    // Two missing fsyncs are tolerated and the data keeps flowing.
    for (int k = 0; k < 2; k++) begin
      fillFrame(); pushModel("t4miss2", frameData[5]);
      sendFrame(1'b0, FRAME_BITS, 0, -1, -1, 0);
      checkOutput("t4_hold", 32'(bus.locked), 32'd1);
    end
    fillFrame(); pushModel("t4restore", frameData[5]);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);

    // The third consecutive miss drops lock on that boundary bit.
    for (int k = 0; k < 2; k++) begin
      fillFrame(); pushModel("t4pre", frameData[5]);
      sendFrame(1'b0, FRAME_BITS, 0, -1, -1, 0);
      checkOutput("t4_still", 32'(bus.locked), 32'd1);
    end
    fillFrame();
    sendFrame(1'b0, 1, 0, -1, -1, 0);
    checkOutput("t4_lost", 32'(bus.locked), 32'd0);
    for (int i = 0; i < 100; i++) applyStimulus(1'($urandom), 1'b0);
    checkOutput("t4_hunting", 32'(bus.locked), 32'd0);
    fillFrame(); pushModel("t4relock", frameData[5]);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);
    checkOutput("t4_relocked", 32'(bus.locked), 32'd1);

    // A slot_sel change mid-frame only takes effect at the next frame.
    fillFrame(); frameData[5] = 8'hA1; frameData[9] = 8'hB2;
    pushModel("t5old", 8'hA1);
    sendFrame(1'b1, FRAME_BITS, 0, -1, 20, 9);
    fillFrame(); frameData[9] = 8'hC3;
    pushModel("t5new", 8'hC3);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);

    // A spurious fsync at bit 100 must not realign the frame.
    bus.slot_sel = 5'd20;
    fillFrame(); frameData[20] = 8'h4E;
    pushModel("t5spur", 8'h4E);
    sendFrame(1'b1, FRAME_BITS, 0, 100, -1, 0);
    checkOutput("t5_locked", 32'(bus.locked), 32'd1);
    fillFrame(); frameData[20] = 8'hE7;
    pushModel("t5after", 8'hE7);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);

    // Reset in the middle of capturing slot 20 returns the outputs to reset values at once.
    fillFrame();
    sendFrame(1'b1, 164, 0, -1, -1, 0);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6_code",   32'(bus.pcm_code), 32'h00);
    checkOutput("t6_lin",    32'(bus.lin_out),  32'h0);
    checkOutput("t6_dac",    32'(bus.dac_out),  32'h80);
    checkOutput("t6_valid",  32'(bus.valid),    32'd0);
    checkOutput("t6_locked", 32'(bus.locked),   32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    reset = 1'b0;
    @(posedge sys_clk);
    #1;
    fillFrame(); frameData[20] = 8'h33;
    pushModel("t6relock", 8'h33);
    sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);
    checkOutput("t6_relocked", 32'(bus.locked), 32'd1);

    // All 256 codes through the last timeslot, checked against the G.711 reference.
    bus.slot_sel = 5'd31;
    for (int c = 0; c < 256; c++) begin
      fillFrame(); frameData[31] = 8'(c);
      pushModel("sweep", 8'(c));
      sendFrame(1'b1, FRAME_BITS, 0, -1, -1, 0);
    end

    repeat (4) @(posedge sys_clk);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
